// File: rtl/host_fifo_pkg.sv
// Shared constants for the host FIFO bridge: payload width and payload-size codes.
package host_fifo_pkg;

  localparam int unsigned FIFO_PAYLOAD_WIDTH = 8;

  localparam logic [1:0] FIFO_D0 = 2'd0;
  localparam logic [1:0] FIFO_D1 = 2'd1;
  localparam logic [1:0] FIFO_D2 = 2'd2;
  localparam logic [1:0] FIFO_D4 = 2'd3;

  // Number of payload bytes carried by a payload-size code.
  function automatic logic [2:0] fifo_payload(input logic [1:0] code);
    logic [2:0] bytes;
    bytes = 3'd0;
    unique case (code)
      FIFO_D0: bytes = 3'd0;
      FIFO_D1: bytes = 3'd1;
      FIFO_D2: bytes = 3'd2;
      FIFO_D4: bytes = 3'd4;
      default: bytes = 3'd0;
    endcase
    return bytes;
  endfunction

endpackage

// File: rtl/host_fifo_sync.sv
// Single-clock FIFO with an occupancy counter and either a registered or show-ahead read port.
module host_fifo_sync
  import host_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned WIDTH     = FIFO_PAYLOAD_WIDTH,
  parameter bit          SHOWAHEAD = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  // Flags come from start-of-cycle occupancy, so a push while full is refused
  // even if a pop frees a slot in the same cycle.
  assign full    = (count_q == FullCount);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

  if (SHOWAHEAD) begin : g_showahead
    assign pop_data = mem[rd_ptr_q];
  end else begin : g_registered
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rd_data_q <= '0;
      end else if (pop_ok) begin
        rd_data_q <= mem[rd_ptr_q];
      end
    end

    assign pop_data = rd_data_q;
  end

endmodule

// File: rtl/host_fifo_bridge.sv
// Bridges a host byte stream and a bus master through independent ingress and egress FIFOs.
module host_fifo_bridge
  import host_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic [FIFO_PAYLOAD_WIDTH-1:0] HOST_RXDATA,
  input  logic                          HOST_RXVALID,
  output logic                          HOST_RXREADY,
  output logic [FIFO_PAYLOAD_WIDTH-1:0] HOST_TXDATA,
  output logic                          HOST_TXVALID,
  input  logic                          HOST_TXREADY,
  input  logic                          RDEN,
  output logic                          RDEMPTY,
  output logic [FIFO_PAYLOAD_WIDTH-1:0] RDDATA,
  input  logic                          WREN,
  output logic                          WRFULL,
  input  logic [FIFO_PAYLOAD_WIDTH-1:0] WRDATA,
  output logic [$clog2(DEPTH):0]        RXLEVEL,
  output logic [$clog2(DEPTH):0]        TXLEVEL,
  output logic [1:0]                    ERR,
  input  logic                          ERRCLR
);

  logic       rx_full;
  logic       tx_empty;
  logic [1:0] err_q, err_d;

  host_fifo_sync #(
    .DEPTH     (DEPTH),
    .WIDTH     (FIFO_PAYLOAD_WIDTH),
    .SHOWAHEAD (1'b0)
  ) u_ingress (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (HOST_RXVALID),
    .push_data (HOST_RXDATA),
    .pop       (RDEN),
    .pop_data  (RDDATA),
    .empty     (RDEMPTY),
    .full      (rx_full),
    .level     (RXLEVEL)
  );

  host_fifo_sync #(
    .DEPTH     (DEPTH),
    .WIDTH     (FIFO_PAYLOAD_WIDTH),
    .SHOWAHEAD (1'b1)
  ) u_egress (
    .clk       (CLK),
    .rst_n     (RESETn),
    .push      (WREN),
    .push_data (WRDATA),
    .pop       (HOST_TXREADY),
    .pop_data  (HOST_TXDATA),
    .empty     (tx_empty),
    .full      (WRFULL),
    .level     (TXLEVEL)
  );

  assign HOST_RXREADY = ~rx_full;
  assign HOST_TXVALID = ~tx_empty;

  // A new error in the clearing cycle wins over the clear.
  always_comb begin
    err_d = ERRCLR ? 2'b00 : err_q;
    if (WREN && WRFULL)   err_d[0] = 1'b1;
    if (RDEN && RDEMPTY)  err_d[1] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) err_q <= 2'b00;
    else         err_q <= err_d;
  end

  assign ERR = err_q;

endmodule

// File: tb/tb_host_fifo_bridge.sv
// Directed self-checking bench for host_fifo_bridge with DEPTH=16.
module tb_host_fifo_bridge;

  localparam int unsigned DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic [7:0] HOST_RXDATA;
  logic       HOST_RXVALID;
  logic       HOST_RXREADY;
  logic [7:0] HOST_TXDATA;
  logic       HOST_TXVALID;
  logic       HOST_TXREADY;
  logic       RDEN;
  logic       RDEMPTY;
  logic [7:0] RDDATA;
  logic       WREN;
  logic       WRFULL;
  logic [7:0] WRDATA;
  logic [4:0] RXLEVEL;
  logic [4:0] TXLEVEL;
  logic [1:0] ERR;
  logic       ERRCLR;

  int n_checks = 0;
  int n_fail   = 0;

  host_fifo_bridge #(.DEPTH(DEPTH)) dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .HOST_RXDATA  (HOST_RXDATA),
    .HOST_RXVALID (HOST_RXVALID),
    .HOST_RXREADY (HOST_RXREADY),
    .HOST_TXDATA  (HOST_TXDATA),
    .HOST_TXVALID (HOST_TXVALID),
    .HOST_TXREADY (HOST_TXREADY),
    .RDEN         (RDEN),
    .RDEMPTY      (RDEMPTY),
    .RDDATA       (RDDATA),
    .WREN         (WREN),
    .WRFULL       (WRFULL),
    .WRDATA       (WRDATA),
    .RXLEVEL      (RXLEVEL),
    .TXLEVEL      (TXLEVEL),
    .ERR          (ERR),
    .ERRCLR       (ERRCLR)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " RXLEVEL"}, 32'(RXLEVEL), 0);
    check({tag, " TXLEVEL"}, 32'(TXLEVEL), 0);
    check({tag, " RDEMPTY"}, 32'(RDEMPTY), 1);
    check({tag, " WRFULL"}, 32'(WRFULL), 0);
    check({tag, " HOST_RXREADY"}, 32'(HOST_RXREADY), 1);
    check({tag, " HOST_TXVALID"}, 32'(HOST_TXVALID), 0);
    check({tag, " RDDATA"}, 32'(RDDATA), 0);
    check({tag, " ERR"}, 32'(ERR), 0);
  endtask

  initial begin
    logic [7:0] seq [5];
    seq[0] = 8'h25; seq[1] = 8'h00; seq[2] = 8'h00; seq[3] = 8'h10; seq[4] = 8'h20;

    RESETn = 1'b0; HOST_RXDATA = '0; HOST_RXVALID = 1'b0; HOST_TXREADY = 1'b0;
    RDEN = 1'b0; WREN = 1'b0; WRDATA = '0; ERRCLR = 1'b0;
    step(); step();
    check_reset_state("reset");
    RESETn = 1'b1;
    step();

    // Ordered ingress with zero bytes and one-cycle fall-through.
    for (int i = 0; i < 5; i++) begin
      HOST_RXVALID = 1'b1; HOST_RXDATA = seq[i];
      step();
      if (i == 0) check("fallthrough RDEMPTY", 32'(RDEMPTY), 0);
    end
    HOST_RXVALID = 1'b0;
    check("rx5 RXLEVEL", 32'(RXLEVEL), 5);
    for (int i = 0; i < 5; i++) begin
      RDEN = 1'b1;
      step();
      check($sformatf("rx5 RDDATA[%0d]", i), 32'(RDDATA), 32'(seq[i]));
    end
    RDEN = 1'b0;
    check("rx5 RDEMPTY", 32'(RDEMPTY), 1);
    check("rx5 ERR", 32'(ERR), 0);

    // Underflow: sticky, RDDATA held, clear, then set-over-clear priority.
    RDEN = 1'b1; step(); RDEN = 1'b0;
    check("underflow ERR", 32'(ERR), 2);
    check("underflow RDDATA", 32'(RDDATA), 32'h20);
    step();
    check("underflow sticky", 32'(ERR), 2);
    ERRCLR = 1'b1; step(); ERRCLR = 1'b0;
    check("errclr ERR", 32'(ERR), 0);
    ERRCLR = 1'b1; RDEN = 1'b1; step(); ERRCLR = 1'b0; RDEN = 1'b0;
    check("set beats clear", 32'(ERR), 2);
    ERRCLR = 1'b1; step(); ERRCLR = 1'b0;

    // Ingress backpressure: 20 offered, 16 accepted.
    for (int i = 0; i < 20; i++) begin
      HOST_RXVALID = 1'b1; HOST_RXDATA = 8'h40 + 8'(i);
      step();
    end
    HOST_RXVALID = 1'b0;
    check("rxfull RXREADY", 32'(HOST_RXREADY), 0);
    check("rxfull RXLEVEL", 32'(RXLEVEL), 16);
    for (int i = 0; i < 16; i++) begin
      RDEN = 1'b1;
      step();
      check($sformatf("rxfull RDDATA[%0d]", i), 32'(RDDATA), 32'h40 + i);
    end
    RDEN = 1'b0;
    check("rxfull drained", 32'(RDEMPTY), 1);
    check("rxfull ERR", 32'(ERR), 0);

    // Egress overflow: 17 writes, 17th dropped.
    for (int i = 0; i < 17; i++) begin
      WREN = 1'b1; WRDATA = 8'h80 + 8'(i);
      step();
    end
    WREN = 1'b0;
    check("txfull WRFULL", 32'(WRFULL), 1);
    check("txfull TXLEVEL", 32'(TXLEVEL), 16);
    check("txfull ERR", 32'(ERR), 1);
    HOST_TXREADY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("txdrain VALID[%0d]", i), 32'(HOST_TXVALID), 1);
      check($sformatf("txdrain DATA[%0d]", i), 32'(HOST_TXDATA), 32'h80 + i);
      step();
    end
    HOST_TXREADY = 1'b0;
    check("txdrain empty", 32'(HOST_TXVALID), 0);
    ERRCLR = 1'b1; step(); ERRCLR = 1'b0;
    check("txdrain errclr", 32'(ERR), 0);

    // Fill both directions to 8, then 40 cycles of simultaneous push/pop.
    for (int i = 0; i < 8; i++) begin
      HOST_RXVALID = 1'b1; HOST_RXDATA = 8'(i);
      WREN = 1'b1; WRDATA = 8'(8'hC0 + 8'(i));
      step();
    end
    check("lvl8 RXLEVEL", 32'(RXLEVEL), 8);
    check("lvl8 TXLEVEL", 32'(TXLEVEL), 8);
    for (int i = 0; i < 40; i++) begin
      HOST_RXDATA = 8'(8 + i); RDEN = 1'b1;
      WRDATA = 8'(8'hC0 + 8'(8 + i)); HOST_TXREADY = 1'b1;
      check($sformatf("steady TXDATA[%0d]", i), 32'(HOST_TXDATA), 32'(8'(8'hC0 + 8'(i))));
      step();
      check($sformatf("steady RDDATA[%0d]", i), 32'(RDDATA), i);
      check($sformatf("steady RXLEVEL[%0d]", i), 32'(RXLEVEL), 8);
      check($sformatf("steady TXLEVEL[%0d]", i), 32'(TXLEVEL), 8);
    end
    HOST_RXVALID = 1'b0; WREN = 1'b0;

    // Drain 3 from each side to reach level 5, then reset mid-transfer.
    for (int i = 0; i < 3; i++) step();
    RDEN = 1'b0; HOST_TXREADY = 1'b0;
    check("pre-reset RXLEVEL", 32'(RXLEVEL), 5);
    check("pre-reset TXLEVEL", 32'(TXLEVEL), 5);
    check("pre-reset RDDATA", 32'(RDDATA), 42);
    RESETn = 1'b0;
    step();
    check_reset_state("midreset");
    RESETn = 1'b1;
    step();
    check("post-reset RDEMPTY", 32'(RDEMPTY), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
